mac_bank_sched: RTL and testbench
=================================

# mac_bank_sched

Layer sequencer for the shared 214-MAC bank. On `start` it walks the enabled layers in fixed order: conv1 → conv2 → fc1 → fc2 → fc3. For each layer it:
- issues feature/weight read addresses, one tap per cycle;
- drives the bank's `sel` and per-layer accumulator-clear lines aligned to the read data;
- flags, with its output index, the cycle on which each finished accumulation is valid on the bank's outputs.

## Interface
Parameters:
- `MAC_LAT`, default 3: cycles from an operand at a MAC input to the updated value on `P`.
- `FA_W`, default 10: width of the feature read address.
- `WA_W`, default 9: width of the weight read address.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: begin a run. Sampled only in IDLE.
- `layer_en`, in, 5: bit0 = conv1 … bit4 = fc3. Sampled with `start`. Disabled layers are skipped.
- `hold`, in, 1: downstream not ready. Honoured only at output boundaries.
- `rd_en`, out, 1: feature/weight memory read strobe. Memory read latency is fixed at 1 cycle.
- `feat_addr`, out, FA_W: feature read address.
- `wt_addr`, out, WA_W: weight read address, i.e. the tap index.
- `sel`, out, 1: bank mode. 1 during conv1/conv2, 0 during fc1/fc2/fc3.
- `conv1_clr`, `conv2_clr`, `fc1_clr`, `fc2_clr`, `fc3_clr`, out, 1 each: accumulator clear/load for the MACs of that layer.
- `layer`, out, 3: active layer code, 0–4.
- `acc_valid`, out, 1: one-cycle pulse; the bank output for the current layer holds a final sum.
- `acc_idx`, out, 10: output index of the sum flagged by `acc_valid`.
- `busy`, out, 1: high from the cycle after the accepted `start` until `done`.
- `done`, out, 1: one-cycle pulse at the end of the run.

Reset value: every output is 0 and the FSM is in IDLE.

## Operation
Layer geometry (T = taps per output, N = outputs):

- **conv1**: IN_W = 32, K = 5, OUT_W = 28. T = 25, N = 784.
  - feat_addr = (oy+ky)·32 + (ox+kx); wt_addr = ky·5 + kx.
- **conv2**: IN_W = 14, K = 5, OUT_W = 10. T = 25, N = 100. Addressing as for conv1 with IN_W = 14.
- **fc1**: T = 400, N = 1. **fc2**: T = 120, N = 1. **fc3**: T = 84, N = 1.
  - For all fc layers, feat_addr = wt_addr = tap.

Counters and indexing:
- Tap counter order is kx innermost, then ky. Output counter order is ox innermost, then oy.
- acc_idx = oy·OUT_W + ox; it is 0 for fc layers.
- Addresses are zero-extended to the port widths.

FSM states:
- **IDLE**
  - On `start`: latch `layer_en`.
  - If `layer_en` is 0, pulse `done` next cycle without setting `busy`.
  - Otherwise go to ISSUE at the lowest enabled layer with all counters at 0.
- **ISSUE**
  - At tap 0 of any output, including the first output of a layer: if `hold` = 1, issue nothing (`rd_en` = 0) and stay.
  - Otherwise issue one tap per cycle with `rd_en` = 1.
  - After the last tap of the last output, go to DRAIN.
- **DRAIN**: lasts 1 + MAC_LAT cycles. Then:
  - go to the next enabled layer's ISSUE;
  - or, if none is left, go to IDLE with a `done` pulse.
- `start` while `busy` is ignored.

Clear and result alignment:
- The layer's `*_clr` is high exactly on the cycle after tap 0 is issued, which is when its read data reaches the MAC.
- `clr` means load the product instead of accumulating. Only the active layer's clr ever toggles.
- A delay line of 1 + MAC_LAT stages carries the last-tap marker and output index. Its output drives `acc_valid` and `acc_idx`.
- The delay line runs regardless of `hold` or state, so results still emerge during hold and DRAIN.
- Between `acc_valid` and the next clr, accumulator contents are don't-care.

Other rules:
- `sel` and `layer` change only on entry to a layer's ISSUE and are held through its DRAIN.
- `rd_en` is 0 in DRAIN and IDLE. Addresses hold their last value while `rd_en` = 0.
- When `rst_n` falls mid-run, all state and the delay line clear immediately. No `acc_valid` or `done` follows.

## Timing
- With `start` seen at cycle 0 and `hold` = 0, the first `rd_en` is at cycle 1. Taps are back-to-back, with no bubbles between outputs.
- Last tap issued at cycle t:
  - `acc_valid` at t + 1 + MAC_LAT;
  - next layer's first `rd_en`, or `done`, at t + 2 + MAC_LAT.
- Each `hold` cycle at a boundary delays all later events by exactly one cycle.
- `busy` falls in the same cycle that `done` pulses.

## Test plan
All scenarios use MAC_LAT = 2.

1. **fc3 only.** `layer_en` = 5'b10000, `start` at cycle 0.
   - `rd_en` cycles 1–84; wt_addr 0–83; `sel` = 0; `layer` = 4.
   - `fc3_clr` at cycle 2 only.
   - `acc_valid` at cycle 87 with `acc_idx` = 0; `done` at 88.
2. **conv1 addressing.**
   - Output 0 feat_addr sequence: 0, 1, 2, 3, 4, 32, …, 132.
   - Output 1 starts at 1; output 28 starts at 32.
   - `conv1_clr` once every 25 cycles. 784 `acc_valid` pulses with `acc_idx` 0–783 in order.
3. **conv2 end.** Last output (oy = 9, ox = 9), tap 24: feat_addr = 195, wt_addr = 24. Final `acc_idx` = 99.
4. **Hold at a boundary.** Hold high for 3 cycles at the conv2 output-1 boundary.
   - 3-cycle `rd_en` gap; `conv2_clr` is on the cycle after the resumed tap 0.
   - Output 0's `acc_valid` still fires on time during the hold.
5. **Full run and layer transitions.** `layer_en` = 5'b11111.
   - `sel` goes 1 → 0 only after conv2's drain.
   - `acc_valid` count = 784 + 100 + 3.
   - `done` once; `start` pulses while `busy` are ignored.
6. **Reset mid-run and empty mask.**
   - `rst_n` low during fc1 tap 200: all outputs 0 at once, no `done`. After release, a new `start` runs cleanly.
   - `layer_en` = 0 with `start`: `done` pulses next cycle and `busy` stays 0.

Source files
------------

// File: rtl/mac_bank_sched.sv
// rtl/mac_bank_sched.sv - layer sequencer driving the shared MAC bank (conv1, conv2, fc1, fc2, fc3)
module mac_bank_sched #(
    parameter int MAC_LAT = 3,
    parameter int FA_W    = 10,
    parameter int WA_W    = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [4:0]      layer_en,
    input  logic            hold,
    output logic            rd_en,
    output logic [FA_W-1:0] feat_addr,
    output logic [WA_W-1:0] wt_addr,
    output logic            sel,
    output logic            conv1_clr,
    output logic            conv2_clr,
    output logic            fc1_clr,
    output logic            fc2_clr,
    output logic            fc3_clr,
    output logic [2:0]      layer,
    output logic            acc_valid,
    output logic [9:0]      acc_idx,
    output logic            busy,
    output logic            done
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t            state, state_nx;
    logic [4:0]        en_q;
    logic [2:0]        lyr_q;
    logic              sel_q;
    logic [8:0]        tap;
    logic [2:0]        kx, ky;
    logic [4:0]        ox, oy;
    logic [7:0]        dcnt;
    logic [FA_W-1:0]   fa_q;
    logic [WA_W-1:0]   wa_q;
    logic              clr_q;
    logic              done_q;
    logic [MAC_LAT:0]        dl_v;
    logic [MAC_LAT:0][9:0]   dl_idx;

    logic              is_conv;
    logic [15:0]       in_w;
    logic [4:0]        out_w;
    logic [8:0]        t_last;
    logic              issue, last_tap, last_out;
    logic [FA_W-1:0]   fa_cur;
    logic [9:0]        idx_cur;
    logic              nxt_found;
    logic [2:0]        nxt_lyr, first_lyr, tgt_lyr;
    logic              go_layer, done_nx;

    always_comb begin
        is_conv = (lyr_q < 3'd2);
        in_w    = (lyr_q == 3'd0) ? 16'd32 : 16'd14;
        out_w   = (lyr_q == 3'd0) ? 5'd28 : 5'd10;
        case (lyr_q)
            3'd0, 3'd1: t_last = 9'd24;
            3'd2:       t_last = 9'd399;
            3'd3:       t_last = 9'd119;
            default:    t_last = 9'd83;
        endcase
        // the only stall point is tap 0 of an output
        issue    = (state == S_ISSUE) && !((tap == 9'd0) && hold);
        last_tap = (tap == t_last);
        last_out = !is_conv || ((ox == out_w - 5'd1) && (oy == out_w - 5'd1));
        fa_cur   = is_conv ? FA_W'((16'(oy) + 16'(ky)) * in_w + 16'(ox) + 16'(kx))
                           : FA_W'(tap);
        idx_cur  = is_conv ? (10'(oy) * 10'(out_w) + 10'(ox)) : 10'd0;
    end

    always_comb begin
        nxt_found = 1'b0;
        nxt_lyr   = 3'd0;
        first_lyr = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (en_q[i] && (i > int'(lyr_q))) begin
                nxt_found = 1'b1;
                nxt_lyr   = 3'(i);
            end
            if (layer_en[i]) first_lyr = 3'(i);
        end
    end

    always_comb begin
        state_nx = state;
        go_layer = 1'b0;
        tgt_lyr  = lyr_q;
        done_nx  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (layer_en == 5'd0) begin
                        done_nx = 1'b1;
                    end else begin
                        state_nx = S_ISSUE;
                        go_layer = 1'b1;
                        tgt_lyr  = first_lyr;
                    end
                end
            end
            S_ISSUE: begin
                if (issue && last_tap && last_out) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (dcnt == 8'(MAC_LAT)) begin
                    if (nxt_found) begin
                        state_nx = S_ISSUE;
                        go_layer = 1'b1;
                        tgt_lyr  = nxt_lyr;
                    end else begin
                        state_nx = S_IDLE;
                        done_nx  = 1'b1;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            en_q   <= 5'd0;
            lyr_q  <= 3'd0;
            sel_q  <= 1'b0;
            tap    <= 9'd0;
            kx     <= 3'd0;
            ky     <= 3'd0;
            ox     <= 5'd0;
            oy     <= 5'd0;
            dcnt   <= 8'd0;
            fa_q   <= '0;
            wa_q   <= '0;
            clr_q  <= 1'b0;
            done_q <= 1'b0;
            dl_v   <= '0;
            dl_idx <= '0;
        end else begin
            state  <= state_nx;
            done_q <= done_nx;
            clr_q  <= issue && (tap == 9'd0);
            dcnt   <= (state == S_DRAIN) ? dcnt + 8'd1 : 8'd0;
            if ((state == S_IDLE) && start) en_q <= layer_en;
            if (go_layer) begin
                lyr_q <= tgt_lyr;
                sel_q <= (tgt_lyr < 3'd2);
            end
            if (issue) begin
                fa_q <= fa_cur;
                wa_q <= WA_W'(tap);
                if (last_tap) begin
                    tap <= 9'd0;
                    kx  <= 3'd0;
                    ky  <= 3'd0;
                    if (last_out) begin
                        ox <= 5'd0;
                        oy <= 5'd0;
                    end else if (ox == out_w - 5'd1) begin
                        ox <= 5'd0;
                        oy <= oy + 5'd1;
                    end else begin
                        ox <= ox + 5'd1;
                    end
                end else begin
                    tap <= tap + 9'd1;
                    if (kx == 3'd4) begin
                        kx <= 3'd0;
                        ky <= ky + 3'd1;
                    end else begin
                        kx <= kx + 3'd1;
                    end
                end
            end
            // result marker pipe runs free so sums surface during hold and drain
            dl_v[0]   <= issue && last_tap;
            dl_idx[0] <= idx_cur;
            for (int i = 1; i <= MAC_LAT; i++) begin
                dl_v[i]   <= dl_v[i-1];
                dl_idx[i] <= dl_idx[i-1];
            end
        end
    end

    assign rd_en     = issue;
    assign feat_addr = issue ? fa_cur : fa_q;
    assign wt_addr   = issue ? WA_W'(tap) : wa_q;
    assign sel       = sel_q;
    assign layer     = lyr_q;
    assign conv1_clr = clr_q && (lyr_q == 3'd0);
    assign conv2_clr = clr_q && (lyr_q == 3'd1);
    assign fc1_clr   = clr_q && (lyr_q == 3'd2);
    assign fc2_clr   = clr_q && (lyr_q == 3'd3);
    assign fc3_clr   = clr_q && (lyr_q == 3'd4);
    assign acc_valid = dl_v[MAC_LAT];
    assign acc_idx   = dl_idx[MAC_LAT];
    assign busy      = (state != S_IDLE);
    assign done      = done_q;
endmodule

// File: tb/tb_mac_bank_sched.sv
// tb/tb_mac_bank_sched.sv - randomized self-checking bench for mac_bank_sched against a tap-list model
module tb_mac_bank_sched;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] layer_en = 5'd0;
    logic       hold = 1'b0;
    logic       rd_en;
    logic [9:0] feat_addr;
    logic [8:0] wt_addr;
    logic       sel;
    logic       conv1_clr, conv2_clr, fc1_clr, fc2_clr, fc3_clr;
    logic [2:0] layer;
    logic       acc_valid;
    logic [9:0] acc_idx;
    logic       busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    mac_bank_sched #(.MAC_LAT(2), .FA_W(10), .WA_W(9)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .layer_en(layer_en), .hold(hold),
        .rd_en(rd_en), .feat_addr(feat_addr), .wt_addr(wt_addr), .sel(sel),
        .conv1_clr(conv1_clr), .conv2_clr(conv2_clr), .fc1_clr(fc1_clr),
        .fc2_clr(fc2_clr), .fc3_clr(fc3_clr), .layer(layer),
        .acc_valid(acc_valid), .acc_idx(acc_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] fa;
        logic [8:0] wa;
        logic [2:0] lyr;
        logic       tap0;
        logic       last;
        logic       last_layer;
        logic [9:0] idx;
    } tap_t;

    tap_t       tq[$];
    int         acq[$];
    logic [9:0] aiq[$];
    logic [9:0] last_fa = 10'd0;
    logic [8:0] last_wa = 9'd0;

    // expected tap stream straight from the layer geometry
    task automatic build_model(input logic [4:0] en);
        int inw, outw, nt;
        tap_t e;
        tq.delete();
        for (int l = 0; l < 5; l++) begin
            if (!en[l]) continue;
            if (l < 2) begin
                inw  = (l == 0) ? 32 : 14;
                outw = (l == 0) ? 28 : 10;
                for (int oy = 0; oy < outw; oy++)
                    for (int ox = 0; ox < outw; ox++)
                        for (int ky = 0; ky < 5; ky++)
                            for (int kx = 0; kx < 5; kx++) begin
                                e.fa = 10'((oy + ky) * inw + ox + kx);
                                e.wa = 9'(ky * 5 + kx);
                                e.lyr = 3'(l);
                                e.tap0 = (ky == 0 && kx == 0);
                                e.last = (ky == 4 && kx == 4);
                                e.last_layer = e.last && (oy == outw - 1) && (ox == outw - 1);
                                e.idx = 10'(oy * outw + ox);
                                tq.push_back(e);
                            end
            end else begin
                nt = (l == 2) ? 400 : (l == 3) ? 120 : 84;
                for (int t = 0; t < nt; t++) begin
                    e.fa = 10'(t);
                    e.wa = 9'(t);
                    e.lyr = 3'(l);
                    e.tap0 = (t == 0);
                    e.last = (t == nt - 1);
                    e.last_layer = e.last;
                    e.idx = 10'd0;
                    tq.push_back(e);
                end
            end
        end
    endtask

    // hold_mode: 0 none, 1 random, 2 cycles 26..28; abort_at >= 0 returns right after that tap issues
    task automatic run_seq(input logic [4:0] en, input int hold_mode, input bit poke_start,
                           input int abort_at, output int obs_done, output int n_done,
                           output int n_acc);
        int c, earliest, clr_cycle, done_cycle, issued, budget;
        logic [2:0] clr_layer, cur_lyr;
        logic exp_rd, exp_acc, exp_busy;
        logic [4:0] exp_clr;
        tap_t h;
        build_model(en);
        acq.delete();
        aiq.delete();
        obs_done = -1; n_done = 0; n_acc = 0;
        earliest = 1; clr_cycle = -1; clr_layer = 3'd0; done_cycle = -1; issued = 0;
        cur_lyr = 3'd0;
        budget = tq.size() * 2 + 200;
        @(posedge clk); #1;
        start = 1'b1; layer_en = en; hold = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rd_en !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_before_start: rd_en=%b busy=%b required 0 0", rd_en, busy);
        end
        c = 1;
        while (1) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (poke_start && (done_cycle < 0 || c < done_cycle)) begin
                start = 1'($urandom_range(0, 1));
                layer_en = 5'($urandom);
            end
            case (hold_mode)
                1:       hold = ($urandom_range(0, 3) == 0);
                2:       hold = (c >= 26 && c <= 28);
                default: hold = 1'b0;
            endcase
            @(negedge clk);
            exp_rd = (tq.size() > 0) && (c >= earliest) && !(tq[0].tap0 && hold);
            n_checks++;
            if (rd_en !== exp_rd) begin
                n_fail++;
                $display("FAIL rd_en cycle %0d: got %b required %b", c, rd_en, exp_rd);
            end
            if (exp_rd) begin
                h = tq.pop_front();
                n_checks++;
                if (feat_addr !== h.fa || wt_addr !== h.wa) begin
                    n_fail++;
                    $display("FAIL addr cycle %0d: got feat=%0d wt=%0d required feat=%0d wt=%0d",
                             c, feat_addr, wt_addr, h.fa, h.wa);
                end
                n_checks++;
                if (layer !== h.lyr || sel !== (h.lyr < 3'd2)) begin
                    n_fail++;
                    $display("FAIL layer_sel cycle %0d: got layer=%0d sel=%b required layer=%0d sel=%b",
                             c, layer, sel, h.lyr, (h.lyr < 3'd2));
                end
                last_fa = h.fa; last_wa = h.wa; cur_lyr = h.lyr;
                if (h.tap0) begin clr_cycle = c + 1; clr_layer = h.lyr; end
                if (h.last) begin acq.push_back(c + 3); aiq.push_back(h.idx); end
                earliest = h.last_layer ? c + 4 : c + 1;
                if (h.last_layer && tq.size() == 0) done_cycle = c + 4;
                issued++;
                if (abort_at >= 0 && issued == abort_at + 1) return;
            end else begin
                n_checks++;
                if (feat_addr !== last_fa || wt_addr !== last_wa) begin
                    n_fail++;
                    $display("FAIL addr_hold cycle %0d: got feat=%0d wt=%0d required feat=%0d wt=%0d",
                             c, feat_addr, wt_addr, last_fa, last_wa);
                end
                if (c < earliest && issued > 0) begin
                    n_checks++;
                    if (layer !== cur_lyr) begin
                        n_fail++;
                        $display("FAIL layer_drain cycle %0d: got %0d required %0d", c, layer, cur_lyr);
                    end
                end
            end
            exp_clr = (c == clr_cycle) ? 5'(5'd1 << clr_layer) : 5'd0;
            n_checks++;
            if ({fc3_clr, fc2_clr, fc1_clr, conv2_clr, conv1_clr} !== exp_clr) begin
                n_fail++;
                $display("FAIL clr cycle %0d: got %b required %b", c,
                         {fc3_clr, fc2_clr, fc1_clr, conv2_clr, conv1_clr}, exp_clr);
            end
            exp_acc = (acq.size() > 0) && (acq[0] == c);
            n_checks++;
            if (acc_valid !== exp_acc) begin
                n_fail++;
                $display("FAIL acc_valid cycle %0d: got %b required %b", c, acc_valid, exp_acc);
            end
            if (exp_acc) begin
                n_checks++;
                if (acc_idx !== aiq[0]) begin
                    n_fail++;
                    $display("FAIL acc_idx cycle %0d: got %0d required %0d", c, acc_idx, aiq[0]);
                end
                void'(acq.pop_front());
                void'(aiq.pop_front());
            end
            if (acc_valid === 1'b1) n_acc++;
            n_checks++;
            if (done !== (c == done_cycle)) begin
                n_fail++;
                $display("FAIL done cycle %0d: got %b required %b", c, done, (c == done_cycle));
            end
            if (done === 1'b1) begin
                n_done++;
                if (obs_done < 0) obs_done = c;
            end
            exp_busy = (done_cycle < 0) || (c < done_cycle);
            n_checks++;
            if (busy !== exp_busy) begin
                n_fail++;
                $display("FAIL busy cycle %0d: got %b required %b", c, busy, exp_busy);
            end
            if (done_cycle >= 0 && c >= done_cycle + 2) break;
            if (c > budget) begin
                n_fail++;
                $display("FAIL run_timeout: cycle %0d reached with %0d taps outstanding, required 0",
                         c, tq.size());
                break;
            end
            c++;
        end
        start = 1'b0;
        n_checks++;
        if (acq.size() != 0) begin
            n_fail++;
            $display("FAIL acc_outstanding: got %0d missing results required 0", acq.size());
        end
    endtask

    task automatic test_reset;
        n_checks++;
        if ({rd_en, busy, done, acc_valid, sel, layer, feat_addr, wt_addr, acc_idx,
             conv1_clr, conv2_clr, fc1_clr, fc2_clr, fc3_clr} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: outputs not all zero (rd_en=%b busy=%b feat=%0d wt=%0d layer=%0d) required 0",
                     rd_en, busy, feat_addr, wt_addr, layer);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_fc3;
        int od, nd, na;
        run_seq(5'b10000, 0, 1'b0, -1, od, nd, na);
        n_checks++;
        if (od != 88) begin
            n_fail++;
            $display("FAIL fc3_done_cycle: got %0d required 88", od);
        end
        n_checks++;
        if (na != 1 || nd != 1) begin
            n_fail++;
            $display("FAIL fc3_counts: got acc=%0d done=%0d required 1 1", na, nd);
        end
    endtask

    task automatic test_conv2_end;
        int od, nd, na;
        run_seq(5'b00010, 0, 1'b0, -1, od, nd, na);
        n_checks++;
        if (od != 2504 || na != 100) begin
            n_fail++;
            $display("FAIL conv2_end: got done=%0d acc=%0d required 2504 100", od, na);
        end
    endtask

    task automatic test_hold_boundary;
        int od, nd, na;
        run_seq(5'b00010, 2, 1'b0, -1, od, nd, na);
        n_checks++;
        if (od != 2507) begin
            n_fail++;
            $display("FAIL hold_shift_done: got %0d required 2507", od);
        end
    endtask

    task automatic test_full_run;
        int od, nd, na;
        run_seq(5'b11111, 1, 1'b1, -1, od, nd, na);
        n_checks++;
        if (na != 887 || nd != 1) begin
            n_fail++;
            $display("FAIL full_run_counts: got acc=%0d done=%0d required 887 1", na, nd);
        end
    endtask

    task automatic test_random_masks;
        int od, nd, na;
        logic [4:0] en;
        for (int k = 0; k < 3; k++) begin
            en = 5'($urandom_range(1, 15)) << 1;
            run_seq(en, 1, 1'b1, -1, od, nd, na);
            n_checks++;
            if (nd != 1) begin
                n_fail++;
                $display("FAIL random_mask_done mask=%b: got %0d done pulses required 1", en, nd);
            end
        end
    endtask

    task automatic test_reset_mid_run;
        int od, nd, na;
        run_seq(5'b00100, 0, 1'b0, 200, od, nd, na);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rd_en, busy, done, acc_valid, sel, layer, feat_addr, wt_addr, acc_idx,
             conv1_clr, conv2_clr, fc1_clr, fc2_clr, fc3_clr} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_run: outputs not zero (rd_en=%b busy=%b feat=%0d layer=%0d) required 0",
                     rd_en, busy, feat_addr, layer);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_fa = 10'd0; last_wa = 9'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || acc_valid !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_quiet cycle %0d: done=%b acc_valid=%b busy=%b rd_en=%b required 0",
                         i, done, acc_valid, busy, rd_en);
            end
        end
        run_seq(5'b10000, 0, 1'b0, -1, od, nd, na);
        n_checks++;
        if (od != 88 || na != 1) begin
            n_fail++;
            $display("FAIL rerun_after_reset: got done=%0d acc=%0d required 88 1", od, na);
        end
    endtask

    task automatic test_empty_mask;
        @(posedge clk); #1;
        start = 1'b1; layer_en = 5'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_mask_pulse: done=%b busy=%b rd_en=%b required 1 0 0", done, busy, rd_en);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_mask_after: done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        test_reset();
        test_fc3();
        test_conv2_end();
        test_hold_boundary();
        test_full_run();
        test_random_masks();
        test_reset_mid_run();
        test_empty_mask();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
